// File: rtl/gpr_wb_queue_pkg.sv
// Shared CPU definitions for the GPR writeback path: widths, register zero,
// and the writeback entry payload.
`timescale 1ns/1ps
package gpr_wb_queue_pkg;

    localparam int unsigned GPR_AW = 5;
    localparam int unsigned GPR_DW = 32;
    localparam int unsigned GPR_NUM = 32;

    localparam logic [GPR_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [GPR_AW-1:0] adr;
        logic [GPR_DW-1:0] data;
    } wb_entry_t;

    // One-hot mask for a register address, used by the pending scoreboard.
    function automatic logic [GPR_NUM-1:0] adr_onehot(input logic [GPR_AW-1:0] adr);
        return GPR_NUM'(1) << adr;
    endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Synchronous FIFO of writeback entries. Pointers wrap modulo DEPTH
// (power of two); full and empty are told apart by the occupancy count.
`timescale 1ns/1ps
module gpr_wb_fifo
    import gpr_wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  wb_entry_t               i_din,
    output wb_entry_t               o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy update; simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/gpr_wb_queue.sv
// Register-file write-port controller: pipeline results take priority,
// long-latency results are queued and drained into idle write cycles, and a
// pending scoreboard flags registers still awaiting a long-latency result.
// Optional macro GPR_WB_BYPASS_EN adds write-cycle bypass outputs.
`timescale 1ns/1ps
module gpr_wb_queue
    import gpr_wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_wr,
    input  logic [GPR_AW-1:0]       pipe_adr,
    input  logic [GPR_DW-1:0]       pipe_data,
    input  logic                    iss_valid,
    input  logic [GPR_AW-1:0]       iss_adr,
    input  logic                    lu_valid,
    input  logic [GPR_AW-1:0]       lu_adr,
    input  logic [GPR_DW-1:0]       lu_data,
    output logic                    lu_ready,
    input  logic [GPR_AW-1:0]       rd_adr1,
    input  logic [GPR_AW-1:0]       rd_adr2,
    output logic                    busy1,
    output logic                    busy2,
    output logic                    GPRWr,
    output logic [GPR_AW-1:0]       DATA_WRITE_ADR,
    output logic [GPR_DW-1:0]       DATA_WRITE,
    output logic [$clog2(DEPTH):0]  fifo_count
`ifdef GPR_WB_BYPASS_EN
    ,
    output logic                    byp_hit1,
    output logic                    byp_hit2,
    output logic [GPR_DW-1:0]       byp_data1,
    output logic [GPR_DW-1:0]       byp_data2
`endif
);

    logic                 w_pipe_sel;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    wb_entry_t            w_head;
    wb_entry_t            w_lu_entry;
    logic [GPR_NUM-1:0]   w_pending_nxt;
    logic [GPR_NUM-1:0]   r_pending;
    logic                 r_wr;
    logic [GPR_AW-1:0]    r_adr;
    logic [GPR_DW-1:0]    r_data;

    // Register-zero writes from the pipeline are ignored so the FIFO may drain.
    assign w_pipe_sel = pipe_wr && (pipe_adr != REG_ZERO);
    assign w_pop      = !w_pipe_sel && !w_empty;
    // Results for register zero complete the handshake but are dropped.
    assign w_push     = lu_valid && !w_full && (lu_adr != REG_ZERO);
    assign lu_ready   = !w_full;
    assign w_lu_entry = '{adr: lu_adr, data: lu_data};

    gpr_wb_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_lu_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Scoreboard next state: clear on FIFO selection, then set on issue.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt = w_pending_nxt & ~adr_onehot(w_head.adr);
        end
        if (iss_valid) begin
            w_pending_nxt = w_pending_nxt | adr_onehot(iss_adr);
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Write-port output registers: pipeline first, then FIFO head, else idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr   <= 1'b0;
            r_adr  <= '0;
            r_data <= '0;
        end else if (w_pipe_sel) begin
            r_wr   <= 1'b1;
            r_adr  <= pipe_adr;
            r_data <= pipe_data;
        end else if (w_pop) begin
            r_wr   <= 1'b1;
            r_adr  <= w_head.adr;
            r_data <= w_head.data;
        end else begin
            r_wr   <= 1'b0;
        end
    end

    assign GPRWr          = r_wr;
    assign DATA_WRITE_ADR = r_adr;
    assign DATA_WRITE     = r_data;

    assign busy1 = (rd_adr1 != REG_ZERO) && r_pending[rd_adr1];
    assign busy2 = (rd_adr2 != REG_ZERO) && r_pending[rd_adr2];

`ifdef GPR_WB_BYPASS_EN
    // Forward the value being written this cycle; the register file read
    // would still return the old contents.
    assign byp_hit1  = r_wr && (r_adr == rd_adr1) && (rd_adr1 != REG_ZERO);
    assign byp_hit2  = r_wr && (r_adr == rd_adr2) && (rd_adr2 != REG_ZERO);
    assign byp_data1 = r_data;
    assign byp_data2 = r_data;
`endif

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Self-checking bench for gpr_wb_queue: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_gpr_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        iv;
        logic [4:0]  ia;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  r1;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_busy;
        logic        e_wr;
        logic [4:0]  e_adr;
        logic [31:0] e_dat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        pipe_wr;
    logic [4:0]  pipe_adr;
    logic [31:0] pipe_data;
    logic        iss_valid;
    logic [4:0]  iss_adr;
    logic        lu_valid;
    logic [4:0]  lu_adr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  rd_adr1;
    logic [4:0]  rd_adr2;
    logic        busy1;
    logic        busy2;
    logic        GPRWr;
    logic [4:0]  DATA_WRITE_ADR;
    logic [31:0] DATA_WRITE;
    logic [2:0]  fifo_count;
`ifdef GPR_WB_BYPASS_EN
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    ent_t        mq[$];
    logic [31:0] mp;
    logic        ewr;
    logic [4:0]  eadr;
    logic [31:0] edata;

    vec_t tv[12];

    gpr_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_wr        (pipe_wr),
        .pipe_adr       (pipe_adr),
        .pipe_data      (pipe_data),
        .iss_valid      (iss_valid),
        .iss_adr        (iss_adr),
        .lu_valid       (lu_valid),
        .lu_adr         (lu_adr),
        .lu_data        (lu_data),
        .lu_ready       (lu_ready),
        .rd_adr1        (rd_adr1),
        .rd_adr2        (rd_adr2),
        .busy1          (busy1),
        .busy2          (busy2),
        .GPRWr          (GPRWr),
        .DATA_WRITE_ADR (DATA_WRITE_ADR),
        .DATA_WRITE     (DATA_WRITE),
        .fifo_count     (fifo_count)
`ifdef GPR_WB_BYPASS_EN
        ,
        .byp_hit1       (byp_hit1),
        .byp_hit2       (byp_hit2),
        .byp_data1      (byp_data1),
        .byp_data2      (byp_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, then check combinational outputs against the model.
    task automatic drive_pre(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                             input logic iv, input logic [4:0] ia,
                             input logic lv, input logic [4:0] la, input logic [31:0] ld,
                             input logic [4:0] r1, input logic [4:0] r2);
        pipe_wr = pw; pipe_adr = pa; pipe_data = pd;
        iss_valid = iv; iss_adr = ia;
        lu_valid = lv; lu_adr = la; lu_data = ld;
        rd_adr1 = r1; rd_adr2 = r2;
        #1;
        chk("lu_ready", 32'(lu_ready), 32'(mq.size() < DEPTH));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("busy1", 32'(busy1), 32'(r1 != 5'd0 && mp[r1]));
        chk("busy2", 32'(busy2), 32'(r2 != 5'd0 && mp[r2]));
`ifdef GPR_WB_BYPASS_EN
        chk("byp_hit1", 32'(byp_hit1), 32'(ewr && eadr == r1 && r1 != 5'd0));
        chk("byp_hit2", 32'(byp_hit2), 32'(ewr && eadr == r2 && r2 != 5'd0));
        if (ewr) chk("byp_data1", byp_data1, edata);
`endif
    endtask

    // Advance the model by the behavioural rules, clock, and check the write port.
    task automatic edge_post();
        bit   accept;
        ent_t e;
        accept = lu_valid && (mq.size() < DEPTH);
        if (pipe_wr && pipe_adr != 5'd0) begin
            ewr = 1'b1; eadr = pipe_adr; edata = pipe_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            ewr = 1'b1; eadr = e.adr; edata = e.data;
            mp[e.adr] = 1'b0;
        end else begin
            ewr = 1'b0;
        end
        if (iss_valid && iss_adr != 5'd0) mp[iss_adr] = 1'b1;
        if (accept && lu_adr != 5'd0) begin
            e.adr = lu_adr; e.data = lu_data;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("GPRWr", 32'(GPRWr), 32'(ewr));
        if (ewr) begin
            chk("DATA_WRITE_ADR", 32'(DATA_WRITE_ADR), 32'(eadr));
            chk("DATA_WRITE", DATA_WRITE, edata);
        end
    endtask

    task automatic step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic iv, input logic [4:0] ia,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        drive_pre(pw, pa, pd, iv, ia, lv, la, ld, r1, r2);
        edge_post();
    endtask

    task automatic idle(input logic [4:0] r1);
        step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    // Assert reset now (async), check cleared outputs, release away from an edge.
    task automatic do_reset();
        rst = 1'b0;
        pipe_wr = 1'b0; iss_valid = 1'b0; lu_valid = 1'b0;
        #1;
        chk("rst_GPRWr", 32'(GPRWr), 32'd0);
        chk("rst_adr", 32'(DATA_WRITE_ADR), 32'd0);
        chk("rst_data", DATA_WRITE, 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        mq.delete();
        mp = '0; ewr = 1'b0; eadr = '0; edata = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        pipe_wr = 0; pipe_adr = 0; pipe_data = 0;
        iss_valid = 0; iss_adr = 0;
        lu_valid = 0; lu_adr = 0; lu_data = 0;
        rd_adr1 = 0; rd_adr2 = 0;
        mp = '0; ewr = 0; eadr = 0; edata = 0;

        // Reset held with inputs toggling: nothing may leak out.
        for (int i = 0; i < 4; i++) begin
            pipe_wr = 1'b1; pipe_adr = 5'(i + 1); pipe_data = $urandom;
            iss_valid = 1'b1; iss_adr = 5'(i + 3);
            lu_valid = 1'b1; lu_adr = 5'(i + 8); lu_data = $urandom;
            rd_adr1 = 5'(i + 3); rd_adr2 = 5'(i + 8);
            @(posedge clk);
            #1;
            chk("hold_GPRWr", 32'(GPRWr), 32'd0);
            chk("hold_lu_ready", 32'(lu_ready), 32'd1);
            chk("hold_fifo_count", 32'(fifo_count), 32'd0);
            chk("hold_busy1", 32'(busy1), 32'd0);
            chk("hold_busy2", 32'(busy2), 32'd0);
        end
        do_reset();

        // Directed vector table.
        tv[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234};
        tv[1]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 1'b0, 5'd0, 32'h0,  5'd7, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        tv[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd7, 3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tv[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd7, 32'h77, 5'd7, 3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tv[4]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 1'b0, 5'd0, 32'h0,  5'd7, 3'd1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h77};
        tv[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd7, 3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tv[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd7, 32'h99, 5'd7, 3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tv[7]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd7, 3'd1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h99};
        tv[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd7, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        tv[9]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 5'd0, 32'h5,  5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        tv[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        tv[11] = '{1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            drive_pre(tv[i].pw, tv[i].pa, tv[i].pd, tv[i].iv, tv[i].ia,
                      tv[i].lv, tv[i].la, tv[i].ld, tv[i].r1, 5'd0);
            chk($sformatf("tv%0d_count", i), 32'(fifo_count), 32'(tv[i].e_cnt));
            chk($sformatf("tv%0d_ready", i), 32'(lu_ready), 32'(tv[i].e_rdy));
            chk($sformatf("tv%0d_busy1", i), 32'(busy1), 32'(tv[i].e_busy));
            edge_post();
            chk($sformatf("tv%0d_wr", i), 32'(GPRWr), 32'(tv[i].e_wr));
            if (tv[i].e_wr) begin
                chk($sformatf("tv%0d_adr", i), 32'(DATA_WRITE_ADR), 32'(tv[i].e_adr));
                chk($sformatf("tv%0d_data", i), DATA_WRITE, tv[i].e_dat);
            end
        end

        // Priority: a queued entry waits behind three pipeline writes.
        do_reset();
        step(0, 0, 0, 1, 9, 1, 9, 32'hAAAA, 9, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 32'(i + 1), 0, 0, 0, 0, 0, 9, 0);
            chk("prio_adr3", 32'(DATA_WRITE_ADR), 32'd3);
            chk("prio_count", 32'(fifo_count), 32'd1);
            chk("prio_busy9", 32'(busy1), 32'd1);
        end
        idle(9);
        chk("prio_adr9", 32'(DATA_WRITE_ADR), 32'd9);
        chk("prio_data9", DATA_WRITE, 32'hAAAA);
        chk("prio_busy9_clr", 32'(busy1), 32'd0);
        idle(0);
        chk("prio_idle", 32'(GPRWr), 32'd0);

        // Full / backpressure with the pipeline holding the port.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 32'(i), 0, 0, 1, 5'(10 + i), 32'(100 + i), 0, 0);
        #1;
        chk("full_ready", 32'(lu_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        step(1, 1, 32'h55, 0, 0, 1, 5'd14, 32'h114, 0, 0);
        chk("full_count_hold", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            idle(0);
            chk("drain_adr", 32'(DATA_WRITE_ADR), 32'(10 + i));
            chk("drain_ready", 32'(lu_ready), 32'd1);
        end
        idle(0);
        chk("drain_done", 32'(GPRWr), 32'd0);

        // pipe_adr == 0 lets the FIFO drain in that cycle.
        do_reset();
        step(1, 4, 32'h44, 0, 0, 1, 5'd20, 32'h2020, 0, 0);
        step(1, 0, 32'hBAD, 0, 0, 0, 0, 0, 0, 0);
        chk("z_drain_adr", 32'(DATA_WRITE_ADR), 32'd20);
        chk("z_drain_data", DATA_WRITE, 32'h2020);

        // Reset mid-drain cuts off the write and discards queued state.
        do_reset();
        step(1, 1, 32'h1, 1, 12, 1, 5'd10, 32'hA, 12, 0);
        step(1, 2, 32'h2, 0, 0, 1, 5'd11, 32'hB, 12, 0);
        step(1, 3, 32'h3, 0, 0, 1, 5'd12, 32'hC, 12, 0);
        idle(12);
        chk("mid_wr_active", 32'(GPRWr), 32'd1);
        do_reset();
        idle(12);
        chk("mid_after_wr", 32'(GPRWr), 32'd0);

        // Randomized traffic against the model, with bias shifting per phase.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic pw;
            logic lv;
            if (((i / 100) % 2) == 0) pw = ($urandom_range(0, 3) != 0);
            else                      pw = ($urandom_range(0, 3) == 0);
            lv = ($urandom_range(0, 1) == 1);
            step(pw, 5'($urandom), $urandom, ($urandom_range(0, 2) == 0), 5'($urandom),
                 lv, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom), $urandom,
                 5'($urandom), 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_queue.md
# gpr_wb_queue

Write-side controller for the general-purpose register file: merges single-cycle pipeline results and long-latency unit results (mult/div, uncached loads) onto the register file's single write port. Long-latency results are buffered in a small FIFO and drained only when the pipeline is not writing. A 32-bit pending scoreboard tells the decode stage which registers still await a long-latency result. Sits between the writeback stage / long-latency units and the register file's GPRWr / DATA_WRITE_ADR / DATA_WRITE inputs.

## Interface
- DEPTH, 4: long-latency result FIFO entries, power of two, 2..16.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- pipe_wr  in  1  pipeline writeback valid this cycle.
- pipe_adr  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- iss_valid  in  1  a long-latency op with destination iss_adr issues this cycle.
- iss_adr  in  5  destination of the issuing long-latency op.
- lu_valid  in  1  long-latency result offered.
- lu_adr  in  5  long-latency result destination.
- lu_data  in  32  long-latency result.
- lu_ready  out  1  FIFO can accept; equals !full.
- rd_adr1, rd_adr2  in  5 each  decode read addresses for hazard lookup.
- busy1, busy2  out  1 each  pending[rd_adrN]; 0 when rd_adrN == 0.
- GPRWr  out  1  register file write enable (registered).
- DATA_WRITE_ADR  out  5  register file write address (registered).
- DATA_WRITE  out  32  register file write data (registered).
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Write-port selection each cycle, priority order:
  1. pipe_wr && pipe_adr != 0 → next write = pipeline result.
  2. Otherwise, FIFO non-empty → next write = FIFO head, which is popped.
  3. Otherwise → GPRWr next = 0.
- pipe_wr with pipe_adr == 0 is treated as no pipeline write; the FIFO may drain that cycle.
- Enqueue on lu_valid && lu_ready. A result with lu_adr == 0 is accepted (handshake completes) but not stored.
- lu_ready = !full, combinational from occupancy only. No same-cycle pass-through when full, even if a pop occurs.
- Push and pop in the same cycle: occupancy unchanged; the pushed entry goes to the tail.
- A pushed entry is never the pop candidate in the same cycle.
- Scoreboard pending[31:0]:
  - Set bit iss_adr on iss_valid && iss_adr != 0.
  - Clear bit DATA_WRITE_ADR when a FIFO entry is selected for the write port, i.e. on the cycle the registered outputs load it.
  - Same bit set and cleared in one cycle: set wins.
  - pending[0] is always 0.
- Pipeline writes never touch the scoreboard.
- Producers guarantee at most one outstanding long-latency op per register; this block does not check it.
- busy1/busy2 are combinational from pending and rd_adr1/rd_adr2.

## Timing
- Pipeline write at cycle N → GPRWr = 1 with its address and data during cycle N+1; the register file captures it at the end of N+1.
- Long-latency result accepted at cycle N → earliest write-port cycle N+2 (stored at N, popped at N+1, driven at N+2).
- Every write-port cycle lasts exactly one clock; GPRWr never holds the same entry twice.
- Reset (async assert, clocked release):
  - GPRWr, DATA_WRITE_ADR, DATA_WRITE = 0.
  - FIFO empty, fifo_count = 0, lu_ready = 1.
  - pending = 0, busy1/busy2 = 0.
- Reset mid-drain discards all FIFO contents and pending bits; a GPRWr pulse in progress is cut off immediately.
- FIFO pointers wrap modulo DEPTH; full is distinguished from empty by the count.

## Configuration
- GPR_WB_BYPASS_EN defined: adds outputs byp_hit1/byp_hit2 (1 bit) and byp_data1/byp_data2 (32 bits).
  - byp_hitN = GPRWr && DATA_WRITE_ADR == rd_adrN && rd_adrN != 0.
  - byp_dataN = DATA_WRITE.
  - Covers the register file's read-during-write-cycle case, where the read returns the old value.
- Undefined: those ports do not exist; decode relies on busy and pipeline stalls alone.

## Structure
- Shared CPU package holds:
  - GPR address width (5) and data width (32) constants.
  - Register-zero constant.
  - wb_entry_t typedef {adr[4:0], data[31:0]}.
- One sub-module is natural: gpr_wb_fifo, a parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count.
- The top level holds the arbitration, the scoreboard, and the output registers.

## Test plan
- Reset: hold rst low with inputs toggling → GPRWr = 0, lu_ready = 1, fifo_count = 0, busy1 = busy2 = 0; release → first write appears no earlier than the cycle after the first pipe_wr.
- Pipeline only: pipe_wr=1, pipe_adr=5, pipe_data=0x1234 at N → N+1 GPRWr=1, DATA_WRITE_ADR=5, DATA_WRITE=0x1234; N+2 GPRWr=0.
- Priority: FIFO holds {9, 0xAAAA}; pipe_wr on adr 3 for 3 cycles → three adr-3 writes, then adr 9 in the following cycle; pending[9] clears when adr 9 is driven.
- Full/backpressure (DEPTH=4): pipe_wr held, push 4 results → lu_ready=0, fifo_count=4; a 5th lu_valid is not accepted; drop pipe_wr → entries written in order, lu_ready=1 after the first pop.
- Scoreboard: iss_valid adr 7, rd_adr1=7 → busy1=1 from the next cycle until the cycle DATA_WRITE_ADR=7 is driven from the FIFO; re-issue of adr 7 in that same cycle → busy1 stays 1.
- Register zero: pipe_adr=0 with a FIFO entry waiting → FIFO drains that cycle; lu_adr=0 accepted, fifo_count unchanged, no write issued; iss_adr=0 → busy never asserted.
